// File: rtl/branch_resolve_pipe.sv
// branch_resolve_pipe: one-cycle registered branch/jump resolution stage.
// Decodes MIPS conditional branches (including branch-likely forms), stages the
// resolved direction with a valid/ready handshake, reports mispredict and
// delay-slot annul, and keeps a PC-indexed 2-bit branch history table whose MSB
// is served to fetch as the prediction.
// Optional build macro: BRANCH_STATS_EN adds saturating branch/mispredict counters.

module branch_resolve_pipe #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      Fetch_PC,
    output logic             Fetch_pred_taken,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [31:0]      Instr_input,
    input  logic [31:0]      PC,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             Jump,
    input  logic             In_pred_taken,
    input  logic             Flush,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Out_taken,
    output logic             Out_is_branch,
    output logic             Out_mispredict,
    output logic             Out_annul,
    output logic [31:0]      Out_PC
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      Stat_branches,
    output logic [31:0]      Stat_mispredicts
`endif
);

    localparam int IDX_BITS = $clog2(BHT_DEPTH);

    // Returns {is_conditional_branch, is_likely, condition_true}.
    function automatic logic [2:0] decode_f(
        input logic [5:0]       op,
        input logic [4:0]       rt,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic a_neg;
        logic a_zero;
        logic is_cond;
        logic likely;
        logic cond;
        a_neg   = a[WIDTH-1];
        a_zero  = (a == {WIDTH{1'b0}});
        is_cond = 1'b0;
        likely  = 1'b0;
        cond    = 1'b0;
        case (op)
            6'b000001: begin
                // REGIMM: rt[4] selects the linking form, rt[1] the likely form.
                case (rt)
                    5'b00000, 5'b10000, 5'b00010, 5'b10010: begin
                        is_cond = 1'b1;
                        likely  = rt[1];
                        cond    = a_neg;
                    end
                    5'b00001, 5'b10001, 5'b00011, 5'b10011: begin
                        is_cond = 1'b1;
                        likely  = rt[1];
                        cond    = !a_neg;
                    end
                    default: begin
                        is_cond = 1'b0;
                    end
                endcase
            end
            6'b000100, 6'b010100: begin
                is_cond = 1'b1;
                likely  = op[4];
                cond    = (a == b);
            end
            6'b000101, 6'b010101: begin
                is_cond = 1'b1;
                likely  = op[4];
                cond    = (a != b);
            end
            6'b000110, 6'b010110: begin
                is_cond = 1'b1;
                likely  = op[4];
                cond    = a_neg || a_zero;
            end
            6'b000111, 6'b010111: begin
                is_cond = 1'b1;
                likely  = op[4];
                cond    = !a_neg && !a_zero;
            end
            default: begin
                is_cond = 1'b0;
            end
        endcase
        return {is_cond, likely, cond};
    endfunction

    // Saturating 2-bit history counter step.
    function automatic logic [1:0] bht_next_f(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) begin
                nxt = ctr + 2'b01;
            end else begin
                nxt = ctr;
            end
        end else begin
            if (ctr != 2'b00) begin
                nxt = ctr - 2'b01;
            end else begin
                nxt = ctr;
            end
        end
        return nxt;
    endfunction

    logic [1:0]          bht_r [BHT_DEPTH];
    logic                out_valid_r;
    logic                out_taken_r;
    logic                out_is_branch_r;
    logic                out_is_cond_r;
    logic                out_mispredict_r;
    logic                out_annul_r;
    logic [31:0]         out_pc_r;

    logic [2:0]          dec_s;
    logic                taken_s;
    logic                is_branch_s;
    logic                is_cond_s;
    logic                annul_s;
    logic                mispredict_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                out_hs_s;
    logic [IDX_BITS-1:0] fetch_idx_s;
    logic [IDX_BITS-1:0] upd_idx_s;
    logic                unused_s;

    assign in_ready_s  = !out_valid_r || Out_ready;
    assign accept_s    = In_valid && in_ready_s && !Flush;
    assign out_hs_s    = out_valid_r && Out_ready && !Flush;
    assign fetch_idx_s = Fetch_PC[IDX_BITS+1:2];
    assign upd_idx_s   = out_pc_r[IDX_BITS+1:2];

    // Instruction fields and PC bits outside the decode and index ranges.
    assign unused_s = ^{Instr_input[25:21], Instr_input[15:0],
                        Fetch_PC[31:IDX_BITS+2], Fetch_PC[1:0]};

    // Resolve the incoming instruction; a jump overrides the opcode decode.
    always_comb begin
        dec_s = decode_f(Instr_input[31:26], Instr_input[20:16], OpA, OpB);
        if (Jump) begin
            taken_s     = 1'b1;
            is_branch_s = 1'b1;
            is_cond_s   = 1'b0;
            annul_s     = 1'b0;
        end else begin
            taken_s     = dec_s[0];
            is_branch_s = dec_s[2];
            is_cond_s   = dec_s[2];
            annul_s     = dec_s[1] && !dec_s[0];
        end
        mispredict_s = is_branch_s && (taken_s != In_pred_taken);
    end

    // Result staging register with valid/ready hold; flush beats a new accept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r      <= 1'b0;
            out_taken_r      <= 1'b0;
            out_is_branch_r  <= 1'b0;
            out_is_cond_r    <= 1'b0;
            out_mispredict_r <= 1'b0;
            out_annul_r      <= 1'b0;
            out_pc_r         <= 32'h0000_0000;
        end else if (Flush) begin
            out_valid_r      <= 1'b0;
            out_mispredict_r <= 1'b0;
            out_annul_r      <= 1'b0;
        end else if (accept_s) begin
            out_valid_r      <= 1'b1;
            out_taken_r      <= taken_s;
            out_is_branch_r  <= is_branch_s;
            out_is_cond_r    <= is_cond_s;
            out_mispredict_r <= mispredict_s;
            out_annul_r      <= annul_s;
            out_pc_r         <= PC;
        end else if (out_hs_s) begin
            out_valid_r      <= 1'b0;
            out_mispredict_r <= 1'b0;
            out_annul_r      <= 1'b0;
        end else begin
            out_valid_r      <= out_valid_r;
        end
    end

    // Branch history table: reset to weakly not-taken, trained on retiring conditional branches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (out_hs_s && out_is_cond_r) begin
            bht_r[upd_idx_s] <= bht_next_f(bht_r[upd_idx_s], out_taken_r);
        end else begin
            bht_r[upd_idx_s] <= bht_r[upd_idx_s];
        end
    end

    assign Fetch_pred_taken = bht_r[fetch_idx_s][1];
    assign In_ready         = in_ready_s;
    assign Out_valid        = out_valid_r;
    assign Out_taken        = out_taken_r;
    assign Out_is_branch    = out_is_branch_r;
    assign Out_mispredict   = out_mispredict_r;
    assign Out_annul        = out_annul_r;
    assign Out_PC           = out_pc_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_r;
    logic [31:0] stat_mp_r;

    // Saturating counters of retired branches and mispredicts.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stat_br_r <= 32'h0000_0000;
            stat_mp_r <= 32'h0000_0000;
        end else if (out_hs_s && out_is_branch_r) begin
            if (stat_br_r != 32'hFFFF_FFFF) begin
                stat_br_r <= stat_br_r + 32'd1;
            end else begin
                stat_br_r <= stat_br_r;
            end
            if (out_mispredict_r && (stat_mp_r != 32'hFFFF_FFFF)) begin
                stat_mp_r <= stat_mp_r + 32'd1;
            end else begin
                stat_mp_r <= stat_mp_r;
            end
        end else begin
            stat_br_r <= stat_br_r;
            stat_mp_r <= stat_mp_r;
        end
    end

    assign Stat_branches    = stat_br_r;
    assign Stat_mispredicts = stat_mp_r;
`endif

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed, table-driven bench for branch_resolve_pipe plus hand-written
// sequences for stall, BHT saturation, jump/flush and reset corner cases.

module tb_branch_resolve_pipe;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Fetch_PC = 32'h0;
    logic        Fetch_pred_taken;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [31:0] Instr_input = 32'h0;
    logic [31:0] PC = 32'h0;
    logic [31:0] OpA = 32'h0;
    logic [31:0] OpB = 32'h0;
    logic        Jump = 1'b0;
    logic        In_pred_taken = 1'b0;
    logic        Flush = 1'b0;
    logic        Out_valid;
    logic        Out_ready = 1'b1;
    logic        Out_taken;
    logic        Out_is_branch;
    logic        Out_mispredict;
    logic        Out_annul;
    logic [31:0] Out_PC;
`ifdef BRANCH_STATS_EN
    logic [31:0] Stat_branches;
    logic [31:0] Stat_mispredicts;
`endif

    branch_resolve_pipe #(.WIDTH(32), .BHT_DEPTH(64)) dut (
        .CLK(CLK), .RESET(RESET), .Fetch_PC(Fetch_PC), .Fetch_pred_taken(Fetch_pred_taken),
        .In_valid(In_valid), .In_ready(In_ready), .Instr_input(Instr_input), .PC(PC),
        .OpA(OpA), .OpB(OpB), .Jump(Jump), .In_pred_taken(In_pred_taken), .Flush(Flush),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_taken(Out_taken),
        .Out_is_branch(Out_is_branch), .Out_mispredict(Out_mispredict),
        .Out_annul(Out_annul), .Out_PC(Out_PC)
`ifdef BRANCH_STATS_EN
        , .Stat_branches(Stat_branches), .Stat_mispredicts(Stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic        jump;
        logic        pred;
        logic        taken;
        logic        br;
        logic        misp;
        logic        annul;
    } vec_t;

    vec_t vecs [16];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one request at the current negedge; returns at the next negedge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic j, input logic p);
        In_valid = 1'b1; Instr_input = instr; PC = pc; OpA = a; OpB = b;
        Jump = j; In_pred_taken = p;
        @(negedge CLK);
        In_valid = 1'b0; Jump = 1'b0;
    endtask

    task automatic check_vec(input int i);
        chk($sformatf("vec%0d_valid", i), {31'b0, Out_valid}, 32'd1);
        chk($sformatf("vec%0d_taken", i), {31'b0, Out_taken}, {31'b0, vecs[i].taken});
        chk($sformatf("vec%0d_isbr", i), {31'b0, Out_is_branch}, {31'b0, vecs[i].br});
        chk($sformatf("vec%0d_misp", i), {31'b0, Out_mispredict}, {31'b0, vecs[i].misp});
        chk($sformatf("vec%0d_annul", i), {31'b0, Out_annul}, {31'b0, vecs[i].annul});
        chk($sformatf("vec%0d_pc", i), Out_PC, 32'h400 + 32'(i * 4));
    endtask

    initial begin
        //            instr         a             b          j     p     tk    br    mp    an
        vecs[0]  = '{32'h10220004, 32'h5,        32'h5,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'h10220004, 32'h5,        32'h6,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h14220004, 32'h5,        32'h6,     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h5C200003, 32'h0,        32'h0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h5C200003, 32'h80000000, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h5C200003, 32'h1,        32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h18200003, 32'h0,        32'h0,     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h04200003, 32'hFFFFFFFF, 32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h04310003, 32'h0,        32'h0,     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h04220003, 32'h1,        32'h0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h04330003, 32'h80000000, 32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{32'h04240003, 32'h0,        32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h00221021, 32'h0,        32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h08000010, 32'h0,        32'h0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{32'h50220004, 32'h3,        32'h4,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{32'h54220004, 32'h3,        32'h3,     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_valid", {31'b0, Out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, In_ready}, 32'd1);
        chk("rst_misp", {31'b0, Out_mispredict}, 32'd0);
        chk("rst_pred", {31'b0, Fetch_pred_taken}, 32'd0);

        // Back-to-back table vectors at PCs 0x400 + 4*i
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (i > 0) check_vec(i - 1);
            chk($sformatf("vec%0d_in_ready", i), {31'b0, In_ready}, 32'd1);
            In_valid = 1'b1; Instr_input = vecs[i].instr; PC = 32'h400 + 32'(i * 4);
            OpA = vecs[i].a; OpB = vecs[i].b; Jump = vecs[i].jump; In_pred_taken = vecs[i].pred;
        end
        @(negedge CLK);
        check_vec(15);
        In_valid = 1'b0; Jump = 1'b0;

        // BEQ taken trains 01 -> 10; fetch sees old value until the handshake edge
        Fetch_PC = 32'h0A0;
        #1;
        chk("bhtA_init", {31'b0, Fetch_pred_taken}, 32'd0);
        issue(32'h10220004, 32'h0A0, 32'h5, 32'h5, 1'b0, 1'b0);
        chk("beq_taken", {31'b0, Out_taken}, 32'd1);
        chk("beq_misp", {31'b0, Out_mispredict}, 32'd1);
        chk("bhtA_old", {31'b0, Fetch_pred_taken}, 32'd0);
        @(negedge CLK);
        chk("bhtA_10", {31'b0, Fetch_pred_taken}, 32'd1);
        chk("drain_valid", {31'b0, Out_valid}, 32'd0);
        chk("drain_misp", {31'b0, Out_mispredict}, 32'd0);
        issue(32'h10220004, 32'h0A0, 32'h1, 32'h2, 1'b0, 1'b1);
        @(negedge CLK);
        chk("bhtA_01", {31'b0, Fetch_pred_taken}, 32'd0);

        // Stall for 3 cycles; release gives one handshake and one update
        Out_ready = 1'b0;
        Fetch_PC = 32'h0B0;
        issue(32'h14220004, 32'h0B0, 32'h1, 32'h2, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", {31'b0, Out_valid}, 32'd1);
            chk("stall_in_ready", {31'b0, In_ready}, 32'd0);
            chk("stall_taken", {31'b0, Out_taken}, 32'd1);
            chk("stall_misp", {31'b0, Out_mispredict}, 32'd1);
            chk("stall_pc", Out_PC, 32'h0B0);
            chk("stall_bht", {31'b0, Fetch_pred_taken}, 32'd0);
            @(negedge CLK);
        end
        Out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, In_ready}, 32'd1);
        @(negedge CLK);
        chk("release_valid", {31'b0, Out_valid}, 32'd0);
        chk("release_bht", {31'b0, Fetch_pred_taken}, 32'd1);
        issue(32'h14220004, 32'h0B0, 32'h7, 32'h7, 1'b0, 1'b1);
        @(negedge CLK);
        chk("single_update", {31'b0, Fetch_pred_taken}, 32'd0);

        // BHT saturation at both ends with BGEZ
        Fetch_PC = 32'h0C0;
        for (int k = 0; k < 4; k++) issue(32'h04210003, 32'h0C0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("bgez_taken", {31'b0, Out_taken}, 32'd1);
        @(negedge CLK);
        chk("sat_hi", {31'b0, Fetch_pred_taken}, 32'd1);
        for (int k = 0; k < 2; k++) issue(32'h04210003, 32'h0C0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        chk("bgez_not_taken", {31'b0, Out_taken}, 32'd0);
        @(negedge CLK);
        chk("sat_hi_then_2nt", {31'b0, Fetch_pred_taken}, 32'd0);
        for (int k = 0; k < 2; k++) issue(32'h04210003, 32'h0C0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        @(negedge CLK);
        chk("sat_lo", {31'b0, Fetch_pred_taken}, 32'd0);
        for (int k = 0; k < 2; k++) issue(32'h04210003, 32'h0C0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("sat_lo_then_2t", {31'b0, Fetch_pred_taken}, 32'd1);

        // Jump leaves BHT alone; flush drops same-cycle input and staged result
        Fetch_PC = 32'h0D0;
        issue(32'h08000010, 32'h0D0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("jump_taken", {31'b0, Out_taken}, 32'd1);
        chk("jump_isbr", {31'b0, Out_is_branch}, 32'd1);
        chk("jump_annul", {31'b0, Out_annul}, 32'd0);
        @(negedge CLK);
        chk("jump_bht", {31'b0, Fetch_pred_taken}, 32'd0);
        Flush = 1'b1;
        issue(32'h10220004, 32'h0D0, 32'h5, 32'h5, 1'b0, 1'b0);
        Flush = 1'b0;
        chk("flush_in_valid", {31'b0, Out_valid}, 32'd0);
        @(negedge CLK);
        chk("flush_in_bht", {31'b0, Fetch_pred_taken}, 32'd0);
        issue(32'h10220004, 32'h0D0, 32'h5, 32'h5, 1'b0, 1'b0);
        chk("pre_flush_valid", {31'b0, Out_valid}, 32'd1);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        chk("flush_out_valid", {31'b0, Out_valid}, 32'd0);
        chk("flush_out_misp", {31'b0, Out_mispredict}, 32'd0);
        chk("flush_out_bht", {31'b0, Fetch_pred_taken}, 32'd0);

        // Reset while stalled discards the result and restores every BHT entry
        Out_ready = 1'b0;
        issue(32'h10220004, 32'h0A0, 32'h5, 32'h5, 1'b0, 1'b0);
        chk("prerst_valid", {31'b0, Out_valid}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        Out_ready = 1'b1;
        chk("midrst_valid", {31'b0, Out_valid}, 32'd0);
        chk("midrst_taken", {31'b0, Out_taken}, 32'd0);
        chk("midrst_isbr", {31'b0, Out_is_branch}, 32'd0);
        chk("midrst_misp", {31'b0, Out_mispredict}, 32'd0);
        chk("midrst_annul", {31'b0, Out_annul}, 32'd0);
        chk("midrst_pc", Out_PC, 32'h0);
        for (int e = 0; e < 64; e++) begin
            Fetch_PC = 32'(e * 4);
            #1;
            chk($sformatf("midrst_bht%0d", e), {31'b0, Fetch_pred_taken}, 32'd0);
        end
`ifdef BRANCH_STATS_EN
        chk("stat_br_rst", Stat_branches, 32'd0);
        chk("stat_mp_rst", Stat_mispredicts, 32'd0);
        @(negedge CLK);
        issue(32'h10220004, 32'h0A0, 32'h5, 32'h5, 1'b0, 1'b0);
        issue(32'h10220004, 32'h0A0, 32'h5, 32'h5, 1'b0, 1'b1);
        @(negedge CLK);
        chk("stat_br", Stat_branches, 32'd2);
        chk("stat_mp", Stat_mispredicts, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
